// File: rtl/tt_rsp_pkg.sv
// rtl/tt_rsp_pkg.sv - shared types and command field constants for tt_reg_responder
package tt_rsp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CMD_ACK   = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_DATA_ACK  = 2'd3
  } rsp_state_t;

  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_ADDR_MSB = 3;
  localparam int CMD_ADDR_LSB = 0;

  localparam logic [7:0] DEFAULT_ID_VAL = 8'hA5;

endpackage

// File: rtl/tt_sync2.sv
// rtl/tt_sync2.sv - two-flop synchronizer for a single asynchronous level
module tt_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tt_reg_responder.sv
// rtl/tt_reg_responder.sv - 4-phase req/ack byte responder into an 8-bit register bank
// TT_RSP_REQ_SYNC_EN inserts a 2-flop synchronizer on req for asynchronous initiators.
module tt_reg_responder
  import tt_rsp_pkg::*;
#(
  parameter int         NREGS  = 16,
  parameter logic [7:0] ID_VAL = DEFAULT_ID_VAL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       req,
  output logic       ack,
  output logic [7:0] dout,
  output logic       busy,
  output logic       err
);

  localparam int         AW      = $clog2(NREGS);
  localparam logic [4:0] NREGS_W = 5'(NREGS);

  logic req_s;

`ifdef TT_RSP_REQ_SYNC_EN
  tt_sync2 u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req),
    .q   (req_s)
  );
`else
  assign req_s = req;
`endif

  rsp_state_t state, state_nx;

  logic       cmd_rw;
  logic [3:0] cmd_addr;
  logic [7:0] regs [1 << AW];

  logic       cap_cmd;
  logic       rd_load;
  logic       wr_go;
  logic [3:0] din_addr;
  logic [7:0] rd_val;
  logic       rd_bad;
  logic       wr_ok;
  logic       wr_bad;

  assign din_addr = din[CMD_ADDR_MSB:CMD_ADDR_LSB];

  // Read data is decoded straight from din so dout loads on the accepting edge.
  always_comb begin
    rd_val = 8'h00;
    rd_bad = 1'b0;
    if (din_addr == 4'd0) begin
      rd_val = ID_VAL;
    end else if ({1'b0, din_addr} < NREGS_W) begin
      rd_val = regs[din_addr[AW-1:0]];
    end else begin
      rd_bad = 1'b1;
    end
  end

  assign wr_bad = !({1'b0, cmd_addr} < NREGS_W);
  assign wr_ok  = (cmd_addr != 4'd0) && !wr_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cap_cmd  = 1'b0;
    wr_go    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_s) begin
          cap_cmd  = 1'b1;
          state_nx = ST_CMD_ACK;
        end
      end
      ST_CMD_ACK: begin
        if (!req_s) begin
          state_nx = cmd_rw ? ST_IDLE : ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (req_s) begin
          wr_go    = 1'b1;
          state_nx = ST_DATA_ACK;
        end
      end
      ST_DATA_ACK: begin
        if (!req_s) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    rd_load = cap_cmd && din[CMD_RW_BIT];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack      <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      dout     <= 8'h00;
      cmd_rw   <= 1'b0;
      cmd_addr <= 4'd0;
      for (int i = 0; i < (1 << AW); i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      ack  <= (state_nx == ST_CMD_ACK) || (state_nx == ST_DATA_ACK);
      // Rises with the first ack, drops one edge after the FSM settles back in IDLE.
      busy <= (state != ST_IDLE) || (state_nx != ST_IDLE);
      if (cap_cmd) begin
        cmd_rw   <= din[CMD_RW_BIT];
        cmd_addr <= din_addr;
      end
      if (rd_load) begin
        dout <= rd_val;
        if (rd_bad) begin
          err <= 1'b1;
        end
      end
      if (wr_go) begin
        if (wr_ok) begin
          regs[cmd_addr[AW-1:0]] <= din;
        end
        if (wr_bad) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule
